// File: rtl/karatsuba_seq_mul.sv
// karatsuba_seq_mul -- sequential unsigned WIDTH x WIDTH multiplier built on
// one Karatsuba split step.
//
// Three partial products share a single (H+1)x(H+1) multiplier:
//    B = Xh*Yh, C = Xl*Yl, A = (Xh+Xl)*(Yh+Yl)
// P = (B << WIDTH) + ((A-B-C) << H) + C
//
// Optional build macro: KARATSUBA_FACTOR_OUT_EN exposes the registered
// factors on a_factor / b_factor / c_factor. These outputs are updated
// together with P.
//
// WIDTH must be even and at least 4.
module karatsuba_seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     X,
   input  logic [WIDTH-1:0]     Y,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   P
`ifdef KARATSUBA_FACTOR_OUT_EN
   ,
   output logic [WIDTH+1:0]     a_factor,
   output logic [WIDTH-1:0]     b_factor,
   output logic [WIDTH-1:0]     c_factor
`endif
);

   localparam int H  = WIDTH / 2;
   localparam int PW = 2 * WIDTH + 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MUL_B   = 3'd1,
      MUL_C   = 3'd2,
      MUL_A   = 3'd3,
      COMBINE = 3'd4
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     x_q;
   logic [WIDTH-1:0]     y_q;
   logic [WIDTH+1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [WIDTH-1:0]     c_q;
   logic                 busy_q;
   logic                 done_q;
   logic [2*WIDTH-1:0]   p_q;

`ifdef KARATSUBA_FACTOR_OUT_EN
   logic [WIDTH+1:0]     a_out_q;
   logic [WIDTH-1:0]     b_out_q;
   logic [WIDTH-1:0]     c_out_q;
`endif

   // Shared multiplier operands and product.
   logic [H:0]           mul_op_x;
   logic [H:0]           mul_op_y;
   logic [2*H+1:0]       mul_res;

   // Combine-stage arithmetic, carried at PW bits so no intermediate wraps.
   logic [PW-1:0]        a_ext;
   logic [PW-1:0]        b_ext;
   logic [PW-1:0]        c_ext;
   logic [PW-1:0]        mid_d;
   logic [PW-1:0]        sum_d;
   logic                 unused_sum_hi;

   // Steer the shared multiplier according to which factor is being formed.
   always_comb begin
      mul_op_x = '0;
      mul_op_y = '0;
      case (state_q)
         MUL_B: begin
            mul_op_x = {1'b0, x_q[WIDTH-1:H]};
            mul_op_y = {1'b0, y_q[WIDTH-1:H]};
         end
         MUL_C: begin
            mul_op_x = {1'b0, x_q[H-1:0]};
            mul_op_y = {1'b0, y_q[H-1:0]};
         end
         MUL_A: begin
            mul_op_x = {1'b0, x_q[WIDTH-1:H]} + {1'b0, x_q[H-1:0]};
            mul_op_y = {1'b0, y_q[WIDTH-1:H]} + {1'b0, y_q[H-1:0]};
         end
         default: begin
            mul_op_x = '0;
            mul_op_y = '0;
         end
      endcase
      mul_res = {{(H+1){1'b0}}, mul_op_x} * {{(H+1){1'b0}}, mul_op_y};
   end

   // Recombine the three factors; the cross term A-B-C is never negative.
   always_comb begin
      a_ext         = {{WIDTH{1'b0}}, a_q};
      b_ext         = {{(WIDTH+2){1'b0}}, b_q};
      c_ext         = {{(WIDTH+2){1'b0}}, c_q};
      mid_d         = a_ext - b_ext - c_ext;
      sum_d         = (b_ext << WIDTH) + (mid_d << H) + c_ext;
      unused_sum_hi = ^sum_d[PW-1:2*WIDTH];
   end

   // Control FSM with registered busy/done/P; B, C, A formed one per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         p_q     <= '0;
`ifdef KARATSUBA_FACTOR_OUT_EN
         a_out_q <= '0;
         b_out_q <= '0;
         c_out_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  x_q     <= X;
                  y_q     <= Y;
                  busy_q  <= 1'b1;
                  state_q <= MUL_B;
               end
            end
            MUL_B: begin
               b_q     <= mul_res[WIDTH-1:0];
               state_q <= MUL_C;
            end
            MUL_C: begin
               c_q     <= mul_res[WIDTH-1:0];
               state_q <= MUL_A;
            end
            MUL_A: begin
               a_q     <= mul_res;
               state_q <= COMBINE;
            end
            COMBINE: begin
               p_q     <= sum_d[2*WIDTH-1:0];
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
`ifdef KARATSUBA_FACTOR_OUT_EN
               a_out_q <= a_q;
               b_out_q <= b_q;
               c_out_q <= c_q;
`endif
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign P    = p_q;

`ifdef KARATSUBA_FACTOR_OUT_EN
   assign a_factor = a_out_q;
   assign b_factor = b_out_q;
   assign c_factor = c_out_q;
`endif

endmodule

// File: tb/tb_karatsuba_seq_mul.sv
// tb_karatsuba_seq_mul -- directed, table-driven checks for karatsuba_seq_mul
// at WIDTH=8 and WIDTH=16. Honours KARATSUBA_FACTOR_OUT_EN when defined.
module tb_karatsuba_seq_mul;

   logic        clk;
   logic        rst_n;
   logic        start8;
   logic [7:0]  X8;
   logic [7:0]  Y8;
   logic        busy8;
   logic        done8;
   logic [15:0] P8;
   logic        start16;
   logic [15:0] X16;
   logic [15:0] Y16;
   logic        busy16;
   logic        done16;
   logic [31:0] P16;
`ifdef KARATSUBA_FACTOR_OUT_EN
   logic [9:0]  a8;
   logic [7:0]  b8;
   logic [7:0]  c8;
   logic [17:0] a16;
   logic [15:0] b16;
   logic [15:0] c16;
`endif

   int checks = 0;
   int errors = 0;

   karatsuba_seq_mul #(.WIDTH(8)) dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start8),
      .X        (X8),
      .Y        (Y8),
      .busy     (busy8),
      .done     (done8),
      .P        (P8)
`ifdef KARATSUBA_FACTOR_OUT_EN
      ,
      .a_factor (a8),
      .b_factor (b8),
      .c_factor (c8)
`endif
   );

   karatsuba_seq_mul #(.WIDTH(16)) dut16 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start16),
      .X        (X16),
      .Y        (Y16),
      .busy     (busy16),
      .done     (done16),
      .P        (P16)
`ifdef KARATSUBA_FACTOR_OUT_EN
      ,
      .a_factor (a16),
      .b_factor (b16),
      .c_factor (c16)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  x;
      logic [7:0]  y;
      logic [15:0] p;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Start one 8-bit operation from a cycle aligned at posedge+1 and return
   // in the done cycle. Inputs are scrambled right after acceptance.
   // done must rise on the 4th edge after the accepting edge.
   task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
      int first_done;
      int ndone;
      X8 = x;
      Y8 = y;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      X8 = ~x;
      Y8 = ~y;
      chk("busy_after_accept", {63'd0, busy8}, 64'd1);
      first_done = 0;
      ndone = 0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         if (done8) begin
            ndone++;
            if (first_done == 0) first_done = k;
         end
      end
      chk("done_edge8", 64'(first_done), 64'd4);
      chk("done_count8", 64'(ndone), 64'd1);
      chk("busy_in_done8", {63'd0, busy8}, 64'd0);
      $display("op8 X=%02h Y=%02h P=%04h expected=%04h", x, y, P8, exp);
      chk("P8", {48'd0, P8}, {48'd0, exp});
`ifdef KARATSUBA_FACTOR_OUT_EN
      chk("a8", {54'd0, a8}, 64'(({6'd0, x[7:4]} + {6'd0, x[3:0]}) * ({6'd0, y[7:4]} + {6'd0, y[3:0]})));
      chk("b8", {56'd0, b8}, 64'(x[7:4] * y[7:4]));
      chk("c8", {56'd0, c8}, 64'(x[3:0] * y[3:0]));
`endif
   endtask

   task automatic do_op16(input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp);
      int first_done;
      X16 = x;
      Y16 = y;
      start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      X16 = ~x;
      Y16 = ~y;
      first_done = 0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         if (done16 && first_done == 0) first_done = k;
      end
      chk("done_edge16", 64'(first_done), 64'd4);
      chk("P16", {32'd0, P16}, {32'd0, exp});
   endtask

   initial begin
      int nd;
      logic [15:0] rx;
      logic [15:0] ry;

      vecs[0] = '{8'h00, 8'h00, 16'h0000};
      vecs[1] = '{8'h65, 8'h05, 16'h01F9};
      vecs[2] = '{8'hFF, 8'hFF, 16'hFE01};
      vecs[3] = '{8'h01, 8'h05, 16'h0005};
      vecs[4] = '{8'h0F, 8'hF0, 16'h0E10};
      vecs[5] = '{8'h80, 8'h80, 16'h4000};
      vecs[6] = '{8'hAA, 8'h55, 16'h3872};
      vecs[7] = '{8'h12, 8'h34, 16'h03A8};

      rst_n = 1'b0;
      start8 = 1'b0;
      start16 = 1'b0;
      X8 = 8'h00;
      Y8 = 8'h00;
      X16 = 16'h0000;
      Y16 = 16'h0000;

      // Reset state
      #1;
      chk("rst_busy", {63'd0, busy8}, 64'd0);
      chk("rst_done", {63'd0, done8}, 64'd0);
      chk("rst_P", {48'd0, P8}, 64'd0);
      chk("rst_P16", {32'd0, P16}, 64'd0);
`ifdef KARATSUBA_FACTOR_OUT_EN
      chk("rst_a", {54'd0, a8}, 64'd0);
`endif
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table vectors back to back: each start lands in the previous done cycle
      for (int i = 0; i < 8; i++) begin
         do_op8(vecs[i].x, vecs[i].y, vecs[i].p);
      end
`ifdef KARATSUBA_FACTOR_OUT_EN
      do_op8(8'h65, 8'h05, 16'h01F9);
      chk("a8_req30", {54'd0, a8}, 64'd55);
      chk("b8_req30", {56'd0, b8}, 64'd0);
      chk("c8_req30", {56'd0, c8}, 64'd25);
      do_op8(8'hFF, 8'hFF, 16'hFE01);
      chk("a8_req31", {54'd0, a8}, 64'd900);
`endif

      // Start held high with operands toggling during busy
      X8 = 8'h65;
      Y8 = 8'h05;
      start8 = 1'b1;
      @(posedge clk); #1;
      nd = 0;
      for (int k = 1; k <= 4; k++) begin
         X8 = 8'($urandom);
         Y8 = 8'($urandom);
         @(posedge clk); #1;
         if (done8) nd++;
      end
      chk("held_P", {48'd0, P8}, 64'h01F9);
      start8 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (done8) nd++;
      end
      chk("held_done_count", 64'(nd), 64'd1);
      $display("held-start op P=%04h dones=%0d", P8, nd);

      // Reset asserted while in MUL_A
      X8 = 8'hFF;
      Y8 = 8'hFF;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {63'd0, busy8}, 64'd0);
      chk("abort_done", {63'd0, done8}, 64'd0);
      chk("abort_P", {48'd0, P8}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      nd = 0;
      for (int k = 1; k <= 6; k++) begin
         if (done8) nd++;
         @(posedge clk); #1;
      end
      chk("abort_no_done", 64'(nd), 64'd0);
      $display("abort in MUL_A: dones after reset=%0d", nd);
      do_op8(8'h12, 8'h34, 16'h03A8);

      // WIDTH=16 corner and random sweep
      do_op16(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      $display("op16 X=ffff Y=ffff P=%08h", P16);
      for (int i = 0; i < 1000; i++) begin
         rx = 16'($urandom);
         ry = 16'($urandom);
         do_op16(rx, ry, {16'd0, rx} * {16'd0, ry});
      end
      $display("op16 random sweep: 1000 operations");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
